// File: rtl/adsr_envelope_pkg.sv
// Shared envelope definitions: state encodings, gain ceiling, default step sizes.
package adsr_envelope_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam logic [15:0] GAIN_MAX              = 16'hFFFF;
    localparam logic [15:0] DEF_ATTACK_STEP       = 16'd4096;
    localparam logic [15:0] DEF_DECAY_STEP        = 16'd1024;
    localparam logic [15:0] DEF_SUSTAIN_LEVEL     = 16'd49152;
    localparam logic [15:0] DEF_RELEASE_STEP      = 16'd512;

endpackage

// File: rtl/adsr_envelope_gain_scaler.sv
// Two-stage signed sample x unsigned gain multiply with a matching ready pulse.
module adsr_gain_scaler #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [COEF_W-1:0] gain,
    output logic [DATA_W-1:0] sample_out,
    output logic              new_sample_ready
);

    localparam int PW = DATA_W + COEF_W + 1;

    logic signed [PW-1:0]     sample_ext;
    logic signed [PW-1:0]     gain_ext;
    logic signed [PW-1:0]     prod_p1;
    logic signed [DATA_W-1:0] out_p2;
    logic                     vld_p1;
    logic                     vld_p2;

    // Drop the fractional gain bits; the arithmetic slice floors toward -inf.
    function automatic logic signed [DATA_W-1:0] floor_shift(input logic signed [PW-1:0] p);
        return p[DATA_W+COEF_W-1:COEF_W];
    endfunction

    assign sample_ext = {{(PW-DATA_W){sample_in[DATA_W-1]}}, sample_in};
    assign gain_ext   = {{(PW-COEF_W){1'b0}}, gain};

    // Stage p1: capture the product using the gain present in the accept cycle.
    always_ff @(posedge clk) begin
        if (acc) prod_p1 <= sample_ext * gain_ext;
    end

    // Stage p2: scaled output; cleared by reset so the codec sees silence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      out_p2 <= '0;
        else if (vld_p1) out_p2 <= floor_shift(prod_p1);
    end

    // Valid pipeline; reset discards any sample still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= acc;
            vld_p2 <= vld_p1;
        end
    end

    assign sample_out       = out_p2;
    assign new_sample_ready = vld_p2;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: trigger-driven FSM stepping the gain once per accepted sample.
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int          DATA_W        = 16,
    parameter logic [15:0] ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter logic [15:0] DECAY_STEP    = DEF_DECAY_STEP,
    parameter logic [15:0] SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
    parameter logic [15:0] RELEASE_STEP  = DEF_RELEASE_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              note_start,
    input  logic              note_release,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_in_ready,
    output logic [DATA_W-1:0] sample_out,
    output logic              new_sample_ready,
    output logic [2:0]        env_state,
    output logic [15:0]       env_gain
);

    env_state_t  state_q, state_d, trig_state;
    logic [15:0] gain_q, gain_d;
    logic        ready_q;
    logic        acc;

    // Add a step, clamping at full scale instead of wrapping.
    function automatic logic [15:0] sat_add(input logic [15:0] g, input logic [15:0] step);
        logic [16:0] sum;
        sum = {1'b0, g} + {1'b0, step};
        return sum[16] ? GAIN_MAX : sum[15:0];
    endfunction

    // Subtract a step but never go below the floor; compare first so nothing underflows.
    function automatic logic [15:0] floor_sub(input logic [15:0] g, input logic [15:0] step,
                                              input logic [15:0] flr);
        if ({1'b0, g} >= ({1'b0, step} + {1'b0, flr})) return g - step;
        else                                           return flr;
    endfunction

    assign acc = sample_in_ready & ~ready_q;

    // Ready history starts high so a line already high at reset release is not a new sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_q <= 1'b1;
        else        ready_q <= sample_in_ready;
    end

    // FSM state and gain registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENV_IDLE;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // Triggers first, then the per-sample step of whichever state results.
    always_comb begin
        trig_state = state_q;
        if (note_start)
            trig_state = ENV_ATTACK;
        else if (note_release && (state_q == ENV_ATTACK || state_q == ENV_DECAY ||
                                  state_q == ENV_SUSTAIN))
            trig_state = ENV_RELEASE;

        state_d = trig_state;
        gain_d  = gain_q;
        if (acc) begin
            case (trig_state)
                ENV_IDLE:    gain_d = '0;
                ENV_ATTACK: begin
                    gain_d = sat_add(gain_q, ATTACK_STEP);
                    if (gain_d == GAIN_MAX) state_d = ENV_DECAY;
                end
                ENV_DECAY: begin
                    gain_d = floor_sub(gain_q, DECAY_STEP, SUSTAIN_LEVEL);
                    if (gain_d == SUSTAIN_LEVEL) state_d = ENV_SUSTAIN;
                end
                ENV_SUSTAIN: gain_d = gain_q;
                ENV_RELEASE: begin
                    gain_d = floor_sub(gain_q, RELEASE_STEP, 16'd0);
                    if (gain_d == 16'd0) state_d = ENV_IDLE;
                end
                default: begin
                    state_d = ENV_IDLE;
                    gain_d  = '0;
                end
            endcase
        end
    end

    // Debug view of the FSM registers.
    always_comb begin
        env_state = state_q;
        env_gain  = gain_q;
    end

    adsr_gain_scaler #(
        .DATA_W (DATA_W),
        .COEF_W (16)
    ) u_scaler (
        .clk              (clk),
        .reset            (reset),
        .acc              (acc),
        .sample_in        (sample_in),
        .gain             (gain_q),
        .sample_out       (sample_out),
        .new_sample_ready (new_sample_ready)
    );

endmodule
